// File: rtl/nbit_updown_modcounter.sv
// Modulo-N up/down counter with load, sync clear and wrap/saturate.
// Single clock domain; async active-high reset.
module nbit_updown_modcounter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] Count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  assign at_max = (Count == MAXV);
  assign at_min = (Count == '0);

  // Terminal count follows direction in the same cycle.
  assign tc = en & ((up_dn & at_max) |
                    (~up_dn & at_min));

  // Next-state: clr beats load beats en beats hold.
  always_comb begin
    cnt_nxt  = Count;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf_sticky;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      cnt_nxt = (load_val > MAXV) ?
                MAXV : load_val;
    end else if (en) begin
      if (tc) begin
        ovf_nxt = 1'b1;
        if (SATURATE == 0) begin
          cnt_nxt  = up_dn ? '0 : MAXV;
          wrap_nxt = 1'b1;
        end
      end else begin
        cnt_nxt = up_dn ? Count + ONE :
                          Count - ONE;
      end
    end
  end

  // State register with async reset.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      Count      <= '0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      Count      <= cnt_nxt;
      wrap       <= wrap_nxt;
      ovf_sticky <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_nbit_updown_modcounter.sv
// Bench for nbit_updown_modcounter: three configs
// driven side by side against an integer model.
module tb_nbit_updown_modcounter;

  logic clk;
  logic rst;
  logic [2:0] en_v, ud_v, ld_v, cl_v;
  logic [3:0] lv_s [3];
  logic [3:0] a_cnt, b_cnt;
  logic [2:0] c_cnt;
  logic [2:0] tcv, wrv, ovv;

  int n_chk = 0;
  int n_fail = 0;

  int mc [3];
  int mw [3];
  int mo [3];
  int MODS [3] = '{10, 10, 8};
  int SATS [3] = '{0, 1, 0};
  int MASK [3] = '{15, 15, 7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nbit_updown_modcounter #(
    .WIDTH(4), .MODULUS(10), .SATURATE(0)
  ) u_a (
    .Clk(clk), .rst(rst), .en(en_v[0]),
    .up_dn(ud_v[0]), .load(ld_v[0]),
    .load_val(lv_s[0]), .clr(cl_v[0]),
    .Count(a_cnt), .tc(tcv[0]),
    .wrap(wrv[0]), .ovf_sticky(ovv[0])
  );

  nbit_updown_modcounter #(
    .WIDTH(4), .MODULUS(10), .SATURATE(1)
  ) u_b (
    .Clk(clk), .rst(rst), .en(en_v[1]),
    .up_dn(ud_v[1]), .load(ld_v[1]),
    .load_val(lv_s[1]), .clr(cl_v[1]),
    .Count(b_cnt), .tc(tcv[1]),
    .wrap(wrv[1]), .ovf_sticky(ovv[1])
  );

  nbit_updown_modcounter #(
    .WIDTH(3), .MODULUS(8), .SATURATE(0)
  ) u_c (
    .Clk(clk), .rst(rst), .en(en_v[2]),
    .up_dn(ud_v[2]), .load(ld_v[2]),
    .load_val(lv_s[2][2:0]), .clr(cl_v[2]),
    .Count(c_cnt), .tc(tcv[2]),
    .wrap(wrv[2]), .ovf_sticky(ovv[2])
  );

  function automatic int cnt_of(int d);
    if (d == 0) return int'(a_cnt);
    if (d == 1) return int'(b_cnt);
    return int'(c_cnt);
  endfunction

  function automatic bit exp_tc(int d);
    if (!en_v[d]) return 1'b0;
    if (ud_v[d]) return mc[d] == MODS[d] - 1;
    return mc[d] == 0;
  endfunction

  task automatic idle_all();
    en_v = '0; ud_v = '0;
    ld_v = '0; cl_v = '0;
    for (int d = 0; d < 3; d++) lv_s[d] = '0;
  endtask

  task automatic drive(int d, bit e, bit u,
                       bit l, int lv, bit c);
    en_v[d] = e; ud_v[d] = u;
    ld_v[d] = l; cl_v[d] = c;
    lv_s[d] = 4'(lv);
  endtask

  task automatic model_zero();
    for (int d = 0; d < 3; d++) begin
      mc[d] = 0; mw[d] = 0; mo[d] = 0;
    end
  endtask

  // Apply the rules to the driven inputs, then clock.
  task automatic step();
    for (int d = 0; d < 3; d++) begin
      int lv;
      bit bnd;
      if (cl_v[d]) begin
        mc[d] = 0; mw[d] = 0; mo[d] = 0;
      end else if (ld_v[d]) begin
        lv = int'(lv_s[d]) & MASK[d];
        mc[d] = (lv > MODS[d] - 1) ?
                MODS[d] - 1 : lv;
        mw[d] = 0;
      end else if (en_v[d]) begin
        bnd = ud_v[d] ? (mc[d] == MODS[d] - 1)
                      : (mc[d] == 0);
        mw[d] = 0;
        if (bnd) begin
          mo[d] = 1;
          if (SATS[d] == 0) begin
            mc[d] = ud_v[d] ? 0 : MODS[d] - 1;
            mw[d] = 1;
          end
        end else begin
          mc[d] = ud_v[d] ? mc[d] + 1 : mc[d] - 1;
        end
      end else begin
        mw[d] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_zero();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (cnt_of(d) !== mc[d] || wrv[d] !== 1'b0 ||
          ovv[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset d%0d: cnt=%0d wrap=%b ovf=%b want 0/0/0",
                 d, cnt_of(d), wrv[d], ovv[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    int seq [12] = '{1,2,3,4,5,6,7,8,9,0,1,2};
    @(negedge clk); idle_all();
    drive(0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); idle_all();
      drive(0, 1, 1, 0, 0, 0);
      #1;
      n_chk++;
      if (tcv[0] !== exp_tc(0)) begin
        n_fail++;
        $display("FAIL up_tc i%0d: tc=%b want %b",
                 i, tcv[0], exp_tc(0));
      end
      step();
      n_chk++;
      if (cnt_of(0) !== seq[i] || cnt_of(0) !== mc[0] ||
          wrv[0] !== mw[0][0] || ovv[0] !== mo[0][0]) begin
        n_fail++;
        $display("FAIL up_cnt i%0d: cnt=%0d w=%b o=%b want %0d/%0d/%0d",
                 i, cnt_of(0), wrv[0], ovv[0], seq[i], mw[0], mo[0]);
      end
    end
  endtask

  task automatic test_count_down();
    @(negedge clk); idle_all();
    drive(0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_all();
      drive(0, 1, 0, 0, 0, 0);
      #1;
      n_chk++;
      if (tcv[0] !== exp_tc(0)) begin
        n_fail++;
        $display("FAIL dn_tc i%0d: tc=%b want %b",
                 i, tcv[0], exp_tc(0));
      end
      step();
      n_chk++;
      if (cnt_of(0) !== mc[0] || wrv[0] !== mw[0][0] ||
          ovv[0] !== mo[0][0]) begin
        n_fail++;
        $display("FAIL dn_cnt i%0d: cnt=%0d w=%b o=%b want %0d/%0d/%0d",
                 i, cnt_of(0), wrv[0], ovv[0], mc[0], mw[0], mo[0]);
      end
    end
  endtask

  task automatic test_load();
    int lvs [2] = '{13, 4};
    int want [2] = '{9, 4};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle_all();
      drive(0, 1, 1, 1, lvs[i], 0);
      step();
      n_chk++;
      if (cnt_of(0) !== want[i] || cnt_of(0) !== mc[0] ||
          wrv[0] !== 1'b0 || ovv[0] !== mo[0][0]) begin
        n_fail++;
        $display("FAIL load lv%0d: cnt=%0d w=%b o=%b want %0d/0/%0d",
                 lvs[i], cnt_of(0), wrv[0], ovv[0], want[i], mo[0]);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk); idle_all();
    drive(1, 0, 0, 1, 7, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_all();
      drive(1, 1, 1, 0, 0, 0);
      step();
      n_chk++;
      if (cnt_of(1) !== mc[1] || wrv[1] !== 1'b0 ||
          ovv[1] !== mo[1][0]) begin
        n_fail++;
        $display("FAIL sat i%0d: cnt=%0d w=%b o=%b want %0d/0/%0d",
                 i, cnt_of(1), wrv[1], ovv[1], mc[1], mo[1]);
      end
    end
    @(negedge clk); idle_all();
    drive(1, 1, 1, 0, 0, 1);
    step();
    n_chk++;
    if (cnt_of(1) !== 0 || ovv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clr: cnt=%0d o=%b want 0/0",
               cnt_of(1), ovv[1]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle_all();
    drive(0, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle_all();
      drive(0, 1, 1, 0, 0, 0);
      step();
    end
    n_chk++;
    if (cnt_of(0) !== 6) begin
      n_fail++;
      $display("FAIL pre_rst: cnt=%0d want 6", cnt_of(0));
    end
    #2 rst = 1'b1;
    #1;
    model_zero();
    n_chk++;
    if (cnt_of(0) !== 0 || wrv !== 3'b000 ||
        ovv !== 3'b000) begin
      n_fail++;
      $display("FAIL async_rst: cnt=%0d w=%b o=%b want 0/000/000",
               cnt_of(0), wrv, ovv);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (cnt_of(0) !== 0) begin
      n_fail++;
      $display("FAIL rst_hold: cnt=%0d want 0", cnt_of(0));
    end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    drive(0, 1, 1, 0, 0, 0);
    step();
    n_chk++;
    if (cnt_of(0) !== 1) begin
      n_fail++;
      $display("FAIL rst_rel: cnt=%0d want 1", cnt_of(0));
    end
  endtask

  task automatic test_dir_flip();
    @(negedge clk); idle_all();
    drive(2, 0, 0, 1, 6, 0);
    step();
    @(negedge clk); idle_all();
    drive(2, 1, 1, 0, 0, 0);
    step();
    @(negedge clk); idle_all();
    drive(2, 0, 1, 0, 0, 0);
    #1;
    n_chk++;
    if (tcv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL flip_tc_off: tc=%b want 0", tcv[2]);
    end
    step();
    n_chk++;
    if (cnt_of(2) !== 7 || wrv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL flip_hold: cnt=%0d w=%b want 7/0",
               cnt_of(2), wrv[2]);
    end
    @(negedge clk); idle_all();
    drive(2, 1, 1, 0, 0, 0);
    #1;
    n_chk++;
    if (tcv[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL flip_tc_up: tc=%b want 1", tcv[2]);
    end
    ud_v[2] = 1'b0;
    #1;
    n_chk++;
    if (tcv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL flip_tc_dn: tc=%b want 0", tcv[2]);
    end
    step();
    n_chk++;
    if (cnt_of(2) !== 6 || wrv[2] !== 1'b0 ||
        cnt_of(2) !== mc[2]) begin
      n_fail++;
      $display("FAIL flip_dn: cnt=%0d w=%b want 6/0",
               cnt_of(2), wrv[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); idle_all();
      for (int d = 0; d < 3; d++) begin
        drive(d, $urandom_range(0, 3) != 0,
              1'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 15),
              $urandom_range(0, 24) == 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (tcv[d] !== exp_tc(d)) begin
          n_fail++;
          $display("FAIL rnd_tc i%0d d%0d: tc=%b want %b",
                   i, d, tcv[d], exp_tc(d));
        end
      end
      step();
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (cnt_of(d) !== mc[d] || wrv[d] !== mw[d][0] ||
            ovv[d] !== mo[d][0]) begin
          n_fail++;
          $display("FAIL rnd i%0d d%0d: cnt=%0d w=%b o=%b want %0d/%0d/%0d",
                   i, d, cnt_of(d), wrv[d], ovv[d],
                   mc[d], mw[d], mo[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_saturate();
    test_async_reset();
    test_dir_flip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
